// File: rtl/common_bus_mem_responder_if.sv
// ---------------------------------------------------------------------------
// common_bus_mem_responder_if
//   Memory-side view of the common snoop bus shared by the data-cache
//   controllers. Bundles request, data and response signals.
//
//   master : cache side (drives requests and write data, sees responses)
//   slave  : memory side (sees requests, drives read data and responses)
//
//   Mem_rd / Mem_wr      level requests, held until the matching response
//   Mem_oprn_abort       peer cache supplies data; cancels a pending read
//   Address_Com          request address, stable while a request is high
//   Data_Bus_Com_in      write data
//   Data_Bus_Com_out/oe  read data and its tri-state drive enable
//   Data_in_Bus          read data valid
//   Mem_write_done       write committed
//   protocol_err         one-cycle pulse on an illegal request combination
// ---------------------------------------------------------------------------
interface common_bus_mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  Mem_rd;
  logic                  Mem_wr;
  logic                  Mem_oprn_abort;
  logic [ADDR_WIDTH-1:0] Address_Com;
  logic [DATA_WIDTH-1:0] Data_Bus_Com_in;
  logic [DATA_WIDTH-1:0] Data_Bus_Com_out;
  logic                  Data_Bus_Com_oe;
  logic                  Data_in_Bus;
  logic                  Mem_write_done;
  logic                  protocol_err;

  modport master (
    output Mem_rd, Mem_wr, Mem_oprn_abort, Address_Com, Data_Bus_Com_in,
    input  Data_Bus_Com_out, Data_Bus_Com_oe, Data_in_Bus, Mem_write_done,
           protocol_err
  );

  modport slave (
    input  Mem_rd, Mem_wr, Mem_oprn_abort, Address_Com, Data_Bus_Com_in,
    output Data_Bus_Com_out, Data_Bus_Com_oe, Data_in_Bus, Mem_write_done,
           protocol_err
  );
endinterface

// File: rtl/common_bus_mem_responder.sv
// ---------------------------------------------------------------------------
// common_bus_mem_responder
//   Main-memory model at the memory end of the common snoop bus. Serves one
//   read or write-back at a time after a programmable latency, supports
//   read abort on snoop intervention, and flags illegal request overlap.
//
//   clk    system clock, all logic on posedge
//   rst_n  synchronous active-low reset (memory contents are kept)
//   bus    common_bus_mem_responder_if.slave (see interface header)
// ---------------------------------------------------------------------------
module common_bus_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,   // power of two
  parameter int ADDR_LSB   = 2,
  parameter int RD_LATENCY = 4,     // 1..15
  parameter int WR_LATENCY = 4      // 1..15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  common_bus_mem_responder_if.slave   bus
);

  localparam int          IDX_W   = $clog2(MEM_DEPTH);
  localparam logic [3:0]  RD_LOAD = 4'(RD_LATENCY - 1);
  localparam logic [3:0]  WR_LOAD = 4'(WR_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DATA,
    WR_WAIT,
    WR_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   dvalid_q, dvalid_d;
  logic                   oe_q, oe_d;
  logic                   wdone_q, wdone_d;
  logic                   perr_q, perr_d;
  logic                   rd_q, wr_q;      // previous request levels, for rise detection
  logic                   mem_we;

  logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

  logic [IDX_W-1:0]       req_idx;
  logic                   wr_rise, rd_rise;
  logic                   unused_addr_bits;

  // Upper address bits alias; only the word index selects a location.
  assign req_idx          = bus.Address_Com[ADDR_LSB +: IDX_W];
  assign unused_addr_bits = ^bus.Address_Com;

  assign wr_rise = bus.Mem_wr & ~wr_q;
  assign rd_rise = bus.Mem_rd & ~rd_q;

  // Next-state and next-output logic.
  // NOTE: every variable gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    dvalid_d = dvalid_q;
    oe_d     = oe_q;
    wdone_d  = wdone_q;
    perr_d   = 1'b0;
    mem_we   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.Mem_wr) begin
          // Write wins over a simultaneous read; the read is dropped, not queued.
          idx_d   = req_idx;
          wdata_d = bus.Data_Bus_Com_in;
          cnt_d   = WR_LOAD;
          perr_d  = bus.Mem_rd;
          state_d = WR_WAIT;
        end else if (bus.Mem_rd && !bus.Mem_oprn_abort) begin
          idx_d   = req_idx;
          cnt_d   = RD_LOAD;
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        perr_d = wr_rise;
        if (bus.Mem_oprn_abort || !bus.Mem_rd) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          rdata_d  = mem[idx_q];
          dvalid_d = 1'b1;
          oe_d     = 1'b1;
          state_d  = RD_DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RD_DATA: begin
        // Abort no longer matters once data is on the bus.
        perr_d = wr_rise;
        if (!bus.Mem_rd) begin
          dvalid_d = 1'b0;
          oe_d     = 1'b0;
          state_d  = IDLE;
        end
      end

      WR_WAIT: begin
        // Write-backs are never cancelled, even if Mem_wr drops early.
        perr_d = rd_rise;
        if (cnt_q == 4'd0) begin
          mem_we  = 1'b1;
          wdone_d = 1'b1;
          state_d = WR_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      WR_DONE: begin
        perr_d = rd_rise;
        if (!bus.Mem_wr) begin
          wdone_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      dvalid_q <= 1'b0;
      oe_q     <= 1'b0;
      wdone_q  <= 1'b0;
      perr_q   <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      dvalid_q <= dvalid_d;
      oe_q     <= oe_d;
      wdone_q  <= wdone_d;
      perr_q   <= perr_d;
      rd_q     <= bus.Mem_rd;
      wr_q     <= bus.Mem_wr;
    end
  end

  // NOTE: the storage array has no reset so it maps onto plain RAM; reset only
  // blocks a commit that coincides with the reset edge.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.Data_Bus_Com_out = rdata_q;
  assign bus.Data_Bus_Com_oe  = oe_q;
  assign bus.Data_in_Bus      = dvalid_q;
  assign bus.Mem_write_done   = wdone_q;
  assign bus.protocol_err     = perr_q;

endmodule

// File: tb/tb_common_bus_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_common_bus_mem_responder
//   Self-checking bench: a table of directed transactions, hand-written
//   multi-cycle corner cases, and random traffic compared against a
//   word-array reference memory with transaction-level latency rules.
// ---------------------------------------------------------------------------
module tb_common_bus_mem_responder;

  localparam int RD_LAT = 4;
  localparam int WR_LAT = 4;
  localparam int DEPTH  = 256;
  localparam int BUDGET = 40;

  logic clk;
  logic rst_n;

  common_bus_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  common_bus_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .ADDR_LSB(2),
    .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference memory: one word per index, address aliases modulo DEPTH words.
  logic [31:0] model_mem [DEPTH];

  // Cycle counters of output activity, sampled mid-cycle.
  int cnt_valid = 0;
  int cnt_oe    = 0;
  int cnt_done  = 0;
  int cnt_perr  = 0;

  always @(negedge clk) begin
    if (bus.Data_in_Bus)     cnt_valid <= cnt_valid + 1;
    if (bus.Data_Bus_Com_oe) cnt_oe    <= cnt_oe + 1;
    if (bus.Mem_write_done)  cnt_done  <= cnt_done + 1;
    if (bus.protocol_err)    cnt_perr  <= cnt_perr + 1;
  end

  function automatic int widx(input logic [31:0] addr);
    return int'(addr[9:2]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " valid"}, 32'(bus.Data_in_Bus), 32'd0);
    check({name, " oe"},    32'(bus.Data_Bus_Com_oe), 32'd0);
    check({name, " done"},  32'(bus.Mem_write_done), 32'd0);
    check({name, " perr"},  32'(bus.protocol_err), 32'd0);
    check({name, " dout"},  bus.Data_Bus_Com_out, 32'd0);
  endtask

  // Full write handshake from IDLE. Checks latency, hold and release.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input bit also_rd, input bit early, input string name);
    int k;
    int d0;
    d0 = cnt_done;
    bus.Address_Com     = addr;
    bus.Data_Bus_Com_in = data;
    bus.Mem_wr          = 1'b1;
    if (also_rd) bus.Mem_rd = 1'b1;
    k = 0;
    if (early) begin
      step();
      k = 1;
      bus.Mem_wr = 1'b0;
    end
    while (!bus.Mem_write_done && k < BUDGET) begin
      step();
      k++;
    end
    check({name, " wr latency"}, 32'(k - 1), 32'(WR_LAT));
    if (!early) begin
      step();
      check({name, " done held"}, 32'(bus.Mem_write_done), 32'd1);
    end
    bus.Mem_wr = 1'b0;
    if (also_rd) bus.Mem_rd = 1'b0;
    step();
    check({name, " done clear"}, 32'(bus.Mem_write_done), 32'd0);
    if (early) check({name, " done pulse"}, 32'(cnt_done - d0), 32'd1);
    model_mem[widx(addr)] = data;
  endtask

  // Full read handshake from IDLE (or with Mem_rd already held through reset).
  task automatic do_read(input logic [31:0] addr, input string name, output logic [31:0] got);
    int k;
    int o0;
    o0 = cnt_oe;
    bus.Address_Com = addr;
    bus.Mem_rd      = 1'b1;
    k = 0;
    while (!bus.Data_in_Bus && k < BUDGET) begin
      step();
      k++;
    end
    check({name, " rd latency"}, 32'(k - 1), 32'(RD_LAT));
    check({name, " oe early"}, 32'(cnt_oe - o0), 32'd0);
    check({name, " oe"}, 32'(bus.Data_Bus_Com_oe), 32'd1);
    got = bus.Data_Bus_Com_out;
    step();
    check({name, " valid held"}, 32'(bus.Data_in_Bus), 32'd1);
    bus.Mem_rd = 1'b0;
    step();
    check({name, " valid clear"}, 32'(bus.Data_in_Bus), 32'd0);
    check({name, " oe clear"}, 32'(bus.Data_Bus_Com_oe), 32'd0);
  endtask

  // Read accepted, then aborted after j further wait cycles. Returns in IDLE
  // right after the abort edge so a new request can be issued at once.
  task automatic do_abort_read(input logic [31:0] addr, input int j, input string name);
    int v0;
    int o0;
    v0 = cnt_valid;
    o0 = cnt_oe;
    bus.Address_Com = addr;
    bus.Mem_rd      = 1'b1;
    step();
    repeat (j) step();
    bus.Mem_oprn_abort = 1'b1;
    step();
    bus.Mem_rd         = 1'b0;
    bus.Mem_oprn_abort = 1'b0;
    check({name, " no valid"}, 32'(cnt_valid - v0 + int'(bus.Data_in_Bus)), 32'd0);
    check({name, " no oe"}, 32'(cnt_oe - o0 + int'(bus.Data_Bus_Com_oe)), 32'd0);
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;   // write data, or expected read data
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] got;
    int d0;
    int p0;
    int v0;
    int k;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hCAFE_0001};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'hCAFE_0001};
    vecs[2] = '{1'b1, 32'h0000_0400, 32'hA5A5_A5A5};
    vecs[3] = '{1'b0, 32'h0000_0000, 32'hA5A5_A5A5};
    vecs[4] = '{1'b1, 32'h0000_03FC, 32'h0BAD_F00D};
    vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0BAD_F00D};
    vecs[6] = '{1'b1, 32'h0000_0003, 32'h1111_2222};
    vecs[7] = '{1'b0, 32'h0000_0400, 32'h1111_2222};

    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;

    // Reset held for two edges with a read already requested.
    rst_n               = 1'b0;
    bus.Mem_rd          = 1'b1;
    bus.Mem_wr          = 1'b0;
    bus.Mem_oprn_abort  = 1'b0;
    bus.Address_Com     = 32'h0000_0008;
    bus.Data_Bus_Com_in = 32'd0;
    step();
    step();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    do_read(32'h0000_0008, "post-reset read", got);

    // Bring memory and model to a known all-zero image.
    for (int i = 0; i < DEPTH; i++) do_write(32'(i * 4), 32'd0, 1'b0, 1'b0, "clear");

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, 1'b0, 1'b0, $sformatf("vec%0d", i));
      end else begin
        do_read(vecs[i].addr, $sformatf("vec%0d", i), got);
        check($sformatf("vec%0d data", i), got, vecs[i].data);
      end
    end

    // Abort on the second wait cycle, then a write accepted immediately.
    do_abort_read(32'h0000_0020, 1, "abort");
    do_write(32'h0000_0050, 32'h5555_0050, 1'b0, 1'b0, "after abort");
    do_read(32'h0000_0050, "after abort rb", got);
    check("after abort data", got, 32'h5555_0050);

    // Simultaneous read and write in IDLE.
    p0 = cnt_perr;
    v0 = cnt_valid;
    do_write(32'h0000_0030, 32'h1234_5678, 1'b1, 1'b0, "simul");
    check("simul perr pulse", 32'(cnt_perr - p0), 32'd1);
    check("simul no valid", 32'(cnt_valid - v0), 32'd0);
    do_read(32'h0000_0030, "simul rb", got);
    check("simul data", got, 32'h1234_5678);

    // Write with Mem_wr dropped right after accept still commits.
    do_write(32'h0000_0060, 32'h6060_6060, 1'b0, 1'b1, "early drop");
    do_read(32'h0000_0060, "early drop rb", got);
    check("early drop data", got, 32'h6060_6060);

    // Mem_wr rising during a read: flagged and ignored.
    p0 = cnt_perr;
    d0 = cnt_done;
    bus.Address_Com     = 32'h0000_0010;
    bus.Data_Bus_Com_in = 32'hFFFF_FFFF;
    bus.Mem_rd          = 1'b1;
    step();
    bus.Mem_wr = 1'b1;
    step();
    bus.Mem_wr = 1'b0;
    k = 2;
    while (!bus.Data_in_Bus && k < BUDGET) begin
      step();
      k++;
    end
    check("wr during rd latency", 32'(k - 1), 32'(RD_LAT));
    check("wr during rd data", bus.Data_Bus_Com_out, 32'hCAFE_0001);
    bus.Mem_rd = 1'b0;
    step();
    check("wr during rd perr", 32'(cnt_perr - p0), 32'd1);
    check("wr during rd no done", 32'(cnt_done - d0), 32'd0);

    // Reset two cycles into WR_WAIT discards the write.
    d0 = cnt_done;
    bus.Address_Com     = 32'h0000_0040;
    bus.Data_Bus_Com_in = 32'hDEAD_BEEF;
    bus.Mem_wr          = 1'b1;
    step();
    step();
    step();
    rst_n      = 1'b0;
    bus.Mem_wr = 1'b0;
    step();
    check_idle_outputs("mid-write reset");
    rst_n = 1'b1;
    step();
    step();
    check("mid-write no done", 32'(cnt_done - d0), 32'd0);
    do_read(32'h0000_0040, "mid-write rb", got);
    check("mid-write data", got, 32'h0000_0000);

    // Random traffic against the reference memory.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      int op;
      a  = $urandom;
      d  = $urandom;
      op = $urandom_range(0, 2);
      if (op == 0) begin
        do_write(a, d, 1'b0, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
      end else if (op == 1) begin
        do_read(a, $sformatf("rnd%0d", i), got);
        check($sformatf("rnd%0d data", i), got, model_mem[widx(a)]);
      end else begin
        do_abort_read(a, $urandom_range(0, RD_LAT - 2), $sformatf("rnd%0d", i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
